// File: rtl/music_addr_gen.sv
// Address generator for tone/song ROM playback: loop, one-shot and ping-pong stepping at a programmable rate.
// Latency: a step lands on count at the rising edge; addr_out follows half a cycle later on the falling edge.
// Backpressure: none; enable=0 pauses stepping with the prescaler frozen; start/stop take effect immediately.
module music_addr_gen #(
  parameter int ADDR_W = 7,
  parameter int SEL_W  = 1,
  parameter int DIV_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      enable,
  input  logic [SEL_W-1:0]          song_sel,
  input  logic [1:0]                mode,
  input  logic [ADDR_W-1:0]         last_addr,
  input  logic [DIV_W-1:0]          div,
  output logic [SEL_W+ADDR_W-1:0]   addr_out,
  output logic                      busy,
  output logic                      done,
  output logic                      wrap
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0]        MODE_ONESHOT  = 2'b01;
  localparam logic [1:0]        MODE_PINGPONG = 2'b10;
  localparam logic              DIR_UP        = 1'b0;
  localparam logic              DIR_DOWN      = 1'b1;
  localparam logic [ADDR_W-1:0] CNT_ONE       = ADDR_W'(1);
  localparam logic [DIV_W-1:0]  DIV_ONE       = DIV_W'(1);

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         count_q, count_d;
  logic [DIV_W-1:0]          presc_q, presc_d;
  logic                      dir_q, dir_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [1:0]                mode_q, mode_d;
  logic [ADDR_W-1:0]         last_q, last_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic                      done_q, done_d;
  logic                      wrap_q, wrap_d;
  logic [SEL_W+ADDR_W-1:0]   addr_out_q, addr_out_d;

  // Next-state: start wins over stop and over any step; steps only in RUN with enable high.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    last_d  = last_q;
    div_d   = div_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    if (start) begin
      sel_d   = song_sel;
      mode_d  = mode;
      last_d  = last_addr;
      div_d   = div;
      count_d = '0;
      presc_d = '0;
      dir_d   = DIR_UP;
      state_d = ST_RUN;
    end else if (stop) begin
      state_d = ST_IDLE;
      count_d = '0;
      presc_d = '0;
    end else if (state_q == ST_RUN && enable) begin
      if (presc_q != div_q) begin
        presc_d = presc_q + DIV_ONE;
      end else begin
        presc_d = '0;
        case (mode_q)
          MODE_ONESHOT: begin
            if (count_q == last_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
            end
          end
          MODE_PINGPONG: begin
            // A zero-length song has nowhere to turn; it reports a turnaround every step.
            if (last_q == '0) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end else if (dir_q == DIR_UP) begin
              if (count_q == last_q) begin
                dir_d   = DIR_DOWN;
                count_d = last_q - CNT_ONE;
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q + CNT_ONE;
              end
            end else begin
              if (count_q == '0) begin
                dir_d   = DIR_UP;
                count_d = CNT_ONE;
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q - CNT_ONE;
              end
            end
          end
          default: begin
            // Loop mode; 2'b11 behaves the same way.
            if (count_q == last_q) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
            end
          end
        endcase
      end
    end

    addr_out_d = {sel_q, count_q};
  end

  // Rising-edge state and configuration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      presc_q <= '0;
      dir_q   <= DIR_UP;
      sel_q   <= '0;
      mode_q  <= '0;
      last_q  <= '0;
      div_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      div_q   <= div_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  // Falling-edge output register keeps the ROM address settled ahead of the ROM's rising-edge sample.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      addr_out_q <= '0;
    end else begin
      addr_out_q <= addr_out_d;
    end
  end

  assign addr_out = addr_out_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_music_addr_gen.sv
// Bench for music_addr_gen: directed scenarios followed by random traffic, checked against a step-count model.
// Latency: flags checked 1ns after each rising edge, addr_out 1ns after each falling edge.
// Backpressure: none; every wait is a fixed number of clock cycles.
module tb_music_addr_gen;

  localparam int ADDR_W = 4;
  localparam int SEL_W  = 1;
  localparam int DIV_W  = 8;

  logic                     clk;
  logic                     reset;
  logic                     start;
  logic                     stop;
  logic                     enable;
  logic [SEL_W-1:0]         song_sel;
  logic [1:0]               mode;
  logic [ADDR_W-1:0]        last_addr;
  logic [DIV_W-1:0]         div;
  logic [SEL_W+ADDR_W-1:0]  addr_out;
  logic                     busy;
  logic                     done;
  logic                     wrap;

  music_addr_gen #(.ADDR_W(ADDR_W), .SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .enable    (enable),
    .song_sel  (song_sel),
    .mode      (mode),
    .last_addr (last_addr),
    .div       (div),
    .addr_out  (addr_out),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position derived from the number of steps taken since start.
  int m_state;   // 0 idle, 1 running, 2 finished
  int m_sel, m_mode, m_last, m_div;
  int m_en_cycles, m_steps, m_pos;
  int m_done, m_wrap;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_sel = 0; m_mode = 0; m_last = 0; m_div = 0;
    m_en_cycles = 0; m_steps = 0; m_pos = 0; m_done = 0; m_wrap = 0;
  endtask

  // Position after m_steps steps, from the closed-form shape of each mode.
  task automatic model_apply_step();
    int p, r, prev;
    case (m_mode)
      1: begin
        if (m_steps > m_last) begin
          m_state = 2;
          m_done  = 1;
          m_pos   = m_last;
        end else begin
          m_pos = m_steps;
        end
      end
      2: begin
        if (m_last == 0) begin
          m_pos  = 0;
          m_wrap = 1;
        end else begin
          p     = 2 * m_last;
          r     = m_steps % p;
          m_pos = (r <= m_last) ? r : p - r;
          prev  = (m_steps - 1) % p;
          m_wrap = ((prev == m_last) || (prev == 0 && m_steps > 1)) ? 1 : 0;
        end
      end
      default: begin
        m_pos  = m_steps % (m_last + 1);
        m_wrap = (m_pos == 0) ? 1 : 0;
      end
    endcase
  endtask

  // One clock cycle: drive inputs, advance model at the rising edge, check flags then addr_out.
  task automatic cycle(input logic st, input logic sp, input logic en, input int sel,
                       input int md, input int last, input int dv);
    logic [31:0] tmp;
    start     = st;
    stop      = sp;
    enable    = en;
    tmp       = 32'(sel);  song_sel  = tmp[SEL_W-1:0];
    tmp       = 32'(md);   mode      = tmp[1:0];
    tmp       = 32'(last); last_addr = tmp[ADDR_W-1:0];
    tmp       = 32'(dv);   div       = tmp[DIV_W-1:0];
    @(posedge clk);
    m_done = 0;
    m_wrap = 0;
    if (st) begin
      m_sel = sel; m_mode = md; m_last = last; m_div = dv;
      m_en_cycles = 0; m_steps = 0; m_pos = 0; m_state = 1;
    end else if (sp) begin
      m_state = 0;
      m_pos   = 0;
    end else if (m_state == 1 && en) begin
      m_en_cycles++;
      if (m_en_cycles % (m_div + 1) == 0) begin
        m_steps++;
        model_apply_step();
      end
    end
    #1;
    check_eq("busy", 32'(busy), (m_state == 1) ? 32'd1 : 32'd0);
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("wrap", 32'(wrap), 32'(m_wrap));
    @(negedge clk);
    #1;
    check_eq("addr_out", 32'(addr_out), 32'((m_sel << ADDR_W) | m_pos));
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, en, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; enable = 1'b0;
    song_sel = '0; mode = '0; last_addr = '0; div = '0;
    model_reset();
    #12;
    check_eq("rst_addr_out", 32'(addr_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_wrap", 32'(wrap), 32'd0);
    reset = 1'b1;

    // Idle without start: nothing moves.
    run(3, 1'b1);

    // Loop over the full 4-bit range, 15 -> 0 wrap.
    cycle(1'b1, 1'b0, 1'b1, 0, 0, 15, 0);
    run(20, 1'b1);

    // Rate: div=2, then enable dropped for 4 cycles mid-period.
    cycle(1'b1, 1'b0, 1'b1, 0, 0, 3, 2);
    run(4, 1'b1);
    run(4, 1'b0);
    run(10, 1'b1);

    // One-shot to 5, then hold in the finished state.
    cycle(1'b1, 1'b0, 1'b1, 0, 1, 5, 0);
    run(10, 1'b1);

    // Start from the finished state with the other song.
    cycle(1'b1, 1'b0, 1'b1, 1, 1, 2, 0);
    check_eq("sel_msb", 32'(addr_out[SEL_W+ADDR_W-1]), 32'd1);
    run(6, 1'b1);

    // Ping-pong over 0..3.
    cycle(1'b1, 1'b0, 1'b1, 0, 2, 3, 0);
    run(10, 1'b1);

    // Degenerate length-zero songs in each mode.
    cycle(1'b1, 1'b0, 1'b1, 1, 0, 0, 0);
    run(3, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1, 2, 0, 1);
    run(5, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 0, 1, 0, 0);
    run(3, 1'b1);

    // start and stop together: start wins.
    cycle(1'b1, 1'b1, 1'b1, 1, 3, 7, 0);
    run(4, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
    run(2, 1'b1);

    // Asynchronous reset mid-run with count at 9.
    cycle(1'b1, 1'b0, 1'b1, 1, 0, 15, 0);
    run(9, 1'b1);
    check_eq("pre_rst_count", 32'(addr_out[ADDR_W-1:0]), 32'd9);
    #1 reset = 1'b0;
    #1;
    check_eq("arst_addr_out", 32'(addr_out), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_wrap", 32'(wrap), 32'd0);
    model_reset();
    #1 reset = 1'b1;
    run(5, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
